s1_chunk_dispatcher: RTL and testbench

//  Issues per-core feature-chunk assignments for one distribution round: chunk k -> core k, start ID = start_id + k*CHUNK_W.

---
 rtl/s1_chunk_dispatcher_if.sv | 28 ++
 rtl/s1_chunk_dispatcher.sv | 145 ++++++++++++++
 tb/tb_s1_chunk_dispatcher.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s1_chunk_dispatcher_if.sv
// Chunk-assignment handshake between s1_chunk_dispatcher (master) and the per-core feature loaders (slave).
interface s1_chunk_dispatcher_if #(
  parameter int ID_W   = 12,
  parameter int CORE_W = 6,
  parameter int LEN_W  = 6
);
  logic              disp_valid;
  logic              disp_ready;
  logic [CORE_W-1:0] disp_core;
  logic [ID_W-1:0]   disp_id;
  logic [LEN_W-1:0]  disp_len;

  modport master (
    output disp_valid,
    output disp_core,
    output disp_id,
    output disp_len,
    input  disp_ready
  );

  modport slave (
    input  disp_valid,
    input  disp_core,
    input  disp_id,
    input  disp_len,
    output disp_ready
  );
endinterface

// File: rtl/s1_chunk_dispatcher.sv
// s1_chunk_dispatcher: hands out consecutive CHUNK_W-wide feature chunks, chunk k to core k, one per handshake.
// Optional stall-cycle counter is built only when S1_STALL_CNT_EN is defined.
module s1_chunk_dispatcher #(
  parameter int ALL_FEATURE = 3703,
  parameter int ALL_CORE    = 64,
  parameter int CHUNK_SHIFT = 5,
  parameter int ID_W        = 12,
  parameter int CORE_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ID_W-1:0]      start_id_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ID_W-1:0]      last_id_o,
  output logic                 more_o,
  output logic [15:0]          stall_cnt_o,
  s1_chunk_dispatcher_if.master disp
);

  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | presenting chunk core_q / cur_id_q until accepted
  // FIN   | one-cycle done pulse, last_id_o valid
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  localparam logic [ID_W:0]        ALL_F     = (ID_W+1)'(ALL_FEATURE);
  localparam logic [CHUNK_SHIFT:0] LEN_MAX   = (CHUNK_SHIFT+1)'(1 << CHUNK_SHIFT);
  localparam logic [ID_W-1:0]      ID_STEP   = ID_W'(1 << CHUNK_SHIFT);
  localparam logic [CORE_W-1:0]    CORE_LAST = CORE_W'(ALL_CORE - 1);

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [CORE_W-1:0] core_q, core_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic              more_q, more_d;

  logic [ID_W:0]        rem;
  logic [ID_W:0]        end_sum;
  logic [CHUNK_SHIFT:0] len;
  logic                 issue;
  logic                 hs;
  logic                 start_acc;
  logic                 round_end;

  assign issue     = (state_q == ISSUE);
  assign hs        = issue && disp.disp_ready;
  assign start_acc = (state_q == IDLE) && start_i;

  // Sums are one bit wider than an ID so nothing wraps near ALL_FEATURE.
  assign rem = ALL_F - {1'b0, cur_id_q};
  always_comb begin
    len = LEN_MAX;
    if (rem < (ID_W+1)'(LEN_MAX)) len = rem[CHUNK_SHIFT:0];
  end
  assign end_sum   = {1'b0, cur_id_q} + (ID_W+1)'(len);
  assign round_end = (core_q == CORE_LAST) || (end_sum >= ALL_F);

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    core_d    = core_q;
    last_id_d = last_id_q;
    more_d    = more_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          if ({1'b0, start_id_i} < ALL_F) begin
            state_d  = ISSUE;
            cur_id_d = start_id_i;
            core_d   = '0;
          end else begin
            state_d   = FIN;
            last_id_d = ID_W'(ALL_FEATURE);
            more_d    = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          if (round_end) begin
            state_d   = FIN;
            last_id_d = end_sum[ID_W-1:0];
            more_d    = (end_sum < ALL_F);
          end else begin
            core_d   = core_q + CORE_W'(1);
            cur_id_d = cur_id_q + ID_STEP;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_id_q  <= '0;
      core_q    <= '0;
      last_id_q <= '0;
      more_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      core_q    <= core_d;
      last_id_q <= last_id_d;
      more_q    <= more_d;
    end
  end

  // Payload is zeroed outside ISSUE so the bus reads all-zero after reset.
  assign disp.disp_valid = issue;
  assign disp.disp_core  = issue ? core_q   : '0;
  assign disp.disp_id    = issue ? cur_id_q : '0;
  assign disp.disp_len   = issue ? len      : '0;

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == FIN);
  assign last_id_o = last_id_q;
  assign more_o    = more_q;

`ifdef S1_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) stall_d = '0;
    else if (issue && !disp.disp_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_s1_chunk_dispatcher.sv
// Directed self-checking bench for s1_chunk_dispatcher; expected stall count follows S1_STALL_CNT_EN.
module tb_s1_chunk_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [11:0] start_id_i;
  logic        busy_o;
  logic        done_o;
  logic [11:0] last_id_o;
  logic        more_o;
  logic [15:0] stall_cnt_o;

  s1_chunk_dispatcher_if #(.ID_W(12), .CORE_W(6), .LEN_W(6)) dif ();

  s1_chunk_dispatcher dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .start_id_i  (start_id_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .last_id_o   (last_id_o),
    .more_o      (more_o),
    .stall_cnt_o (stall_cnt_o),
    .disp        (dif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_hs, done_cyc, last_hs_cyc, stab_err;
  bit timed_out;
  int got_core [128];
  int got_id   [128];
  int got_len  [128];
  int sa, na, sb, nb;
  bit rnd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_round(input int id);
    start_id_i = 12'(id);
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  // Drives ready per the stall schedule and records every accepted chunk until done.
  task automatic run_chunks();
    int cyc = 0;
    int ca = 0;
    int cb = 0;
    bit r;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [5:0]  pc = '0;
    logic [11:0] pid = '0;
    logic [5:0]  pl = '0;
    n_hs = 0; done_cyc = -1; last_hs_cyc = -1; stab_err = 0; timed_out = 1'b0;
    while (1) begin
      if (n_hs == sa && ca < na) begin r = 1'b0; ca++; end
      else if (n_hs == sb && cb < nb) begin r = 1'b0; cb++; end
      else r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dif.disp_ready = r;
      if (pv && !pr) begin
        if (dif.disp_valid !== 1'b1 || dif.disp_core !== pc || dif.disp_id !== pid || dif.disp_len !== pl)
          stab_err++;
      end
      if (done_o === 1'b1) begin done_cyc = cyc; break; end
      if (dif.disp_valid === 1'b1 && r) begin
        if (n_hs < 128) begin
          got_core[n_hs] = int'(dif.disp_core);
          got_id[n_hs]   = int'(dif.disp_id);
          got_len[n_hs]  = int'(dif.disp_len);
        end
        n_hs++;
        last_hs_cyc = cyc;
      end
      pv = dif.disp_valid; pr = r; pc = dif.disp_core; pid = dif.disp_id; pl = dif.disp_len;
      if (cyc >= 3000) begin timed_out = 1'b1; break; end
      tick();
      cyc++;
    end
    dif.disp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; start_id_i = 12'd0; dif.disp_ready = 1'b0;
    tick(); tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || dif.disp_valid !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b done=%b valid=%b expected 0 0 0", busy_o, done_o, dif.disp_valid);
    if (busy_o !== 1'b0 || done_o !== 1'b0 || dif.disp_valid !== 1'b0) errors++;
    checks++;
    if (dif.disp_core !== 6'd0 || dif.disp_id !== 12'd0 || dif.disp_len !== 6'd0) begin
      errors++;
      $display("FAIL reset_bus: core=%0d id=%0d len=%0d expected 0 0 0", dif.disp_core, dif.disp_id, dif.disp_len);
    end
    checks++;
    if (last_id_o !== 12'd0 || more_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_status: last=%0d more=%b stall=%0d expected 0 0 0", last_id_o, more_o, stall_cnt_o);
    end
    start_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_round();
    int bad = 0;
    sa = -1; na = 0; sb = -1; nb = 0; rnd = 1'b0;
    begin_round(0);
    checks++;
    if (dif.disp_valid !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL full_latency: valid=%b busy=%b expected 1 1", dif.disp_valid, busy_o);
    end
    run_chunks();
    checks++;
    if (timed_out || n_hs !== 64) begin
      errors++;
      $display("FAIL full_count: got %0d chunks (timeout=%0d) expected 64", n_hs, timed_out);
    end
    for (int k = 0; k < 64; k++)
      if (got_core[k] != k || got_id[k] != 32 * k || got_len[k] != 32) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_chunks: %0d chunks wrong, expected 0", bad);
    end
    checks++;
    if (done_cyc - last_hs_cyc !== 1) begin
      errors++;
      $display("FAIL full_done_lat: got %0d cycles expected 1", done_cyc - last_hs_cyc);
    end
    checks++;
    if (last_id_o !== 12'd2048 || more_o !== 1'b1) begin
      errors++;
      $display("FAIL full_last: last=%0d more=%b expected 2048 1", last_id_o, more_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse: done=%b busy=%b expected 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_tail_round();
    int bad = 0;
    int id, exp_len;
    sa = -1; na = 0; sb = -1; nb = 0; rnd = 1'b0;
    begin_round(2048);
    run_chunks();
    checks++;
    if (timed_out || n_hs !== 52) begin
      errors++;
      $display("FAIL tail_count: got %0d chunks expected 52", n_hs);
    end
    for (int k = 0; k < 52; k++) begin
      id = 2048 + 32 * k;
      exp_len = (3703 - id < 32) ? 3703 - id : 32;
      if (got_core[k] != k || got_id[k] != id || got_len[k] != exp_len) bad++;
    end
    checks++;
    if (bad !== 0 || got_id[51] !== 3680 || got_len[51] !== 23) begin
      errors++;
      $display("FAIL tail_chunks: bad=%0d last id=%0d len=%0d expected 0 3680 23", bad, got_id[51], got_len[51]);
    end
    checks++;
    if (last_id_o !== 12'd3703 || more_o !== 1'b0) begin
      errors++;
      $display("FAIL tail_last: last=%0d more=%b expected 3703 0", last_id_o, more_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    sa = 10; na = 5; sb = -1; nb = 0; rnd = 1'b1;
    begin_round(0);
    run_chunks();
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable stall cycles expected 0", stab_err);
    end
    checks++;
    if (timed_out || n_hs !== 64) begin
      errors++;
      $display("FAIL bp_count: got %0d chunks expected 64", n_hs);
    end
    for (int k = 0; k < 64; k++)
      if (got_core[k] != k || got_id[k] != 32 * k || got_len[k] != 32) bad++;
    checks++;
    if (bad !== 0 || last_id_o !== 12'd2048) begin
      errors++;
      $display("FAIL bp_chunks: bad=%0d last=%0d expected 0 2048", bad, last_id_o);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    begin_round(3703);
    checks++;
    if (done_o !== 1'b1 || dif.disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL oor_done: done=%b valid=%b expected 1 0", done_o, dif.disp_valid);
    end
    checks++;
    if (last_id_o !== 12'd3703 || more_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_last: last=%0d more=%b expected 3703 0", last_id_o, more_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || dif.disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL oor_after: done=%b busy=%b valid=%b expected 0 0 0", done_o, busy_o, dif.disp_valid);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    dif.disp_ready = 1'b1;
    begin_round(0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (dif.disp_core !== 6'd20 || dif.disp_id !== 12'd640) begin
      errors++;
      $display("FAIL abort_pos: core=%0d id=%0d expected 20 640", dif.disp_core, dif.disp_id);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dif.disp_ready = 1'b0;
    checks++;
    if (dif.disp_valid !== 1'b0 || busy_o !== 1'b0 || last_id_o !== 12'd0 || more_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: valid=%b busy=%b last=%0d more=%b expected 0 0 0 0",
               dif.disp_valid, busy_o, last_id_o, more_o);
    end
    if (done_o === 1'b1) dones++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_o === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses expected 0", dones);
    end
    sa = -1; na = 0; sb = -1; nb = 0; rnd = 1'b0;
    begin_round(0);
    run_chunks();
    checks++;
    if (timed_out || n_hs !== 64 || last_id_o !== 12'd2048 || more_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerun: chunks=%0d last=%0d more=%b expected 64 2048 1", n_hs, last_id_o, more_o);
    end
    tick();
  endtask

  task automatic test_stall_cnt();
`ifdef S1_STALL_CNT_EN
    logic [15:0] exp_stall = 16'd7;
`else
    logic [15:0] exp_stall = 16'd0;
`endif
    sa = 5; na = 3; sb = 30; nb = 4; rnd = 1'b0;
    begin_round(0);
    checks++;
    if (stall_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL stall_clear: got %0d expected 0", stall_cnt_o);
    end
    run_chunks();
    checks++;
    if (timed_out || n_hs !== 64 || stall_cnt_o !== exp_stall) begin
      errors++;
      $display("FAIL stall_count: chunks=%0d stall=%0d expected 64 %0d", n_hs, stall_cnt_o, exp_stall);
    end
    tick(); tick();
    checks++;
    if (stall_cnt_o !== exp_stall) begin
      errors++;
      $display("FAIL stall_hold: got %0d expected %0d", stall_cnt_o, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_tail_round();
    test_backpressure();
    test_out_of_range();
    test_reset_abort();
    test_stall_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
